fpdiv_seq: RTL and testbench

//  Issue sequencer directly upstream of fpdiv. Buffers divide requests in a small queue and drives

---
 rtl/fpdiv_seq_pkg.sv | 25 ++
 rtl/fpdiv_seq_fifo.sv | 43 ++++
 rtl/fpdiv_seq.sv | 214 +++++++++++++++++++++
 tb/tb_fpdiv_seq.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpdiv_seq_pkg.sv
// Shared types and widths for the fpdiv issue sequencer and its request queue.
package fpdiv_seq_pkg;

    localparam int RESULT_W  = 64;
    localparam int FLAGS_W   = 5;
    // Tag field width stored per request; the top's TAG_W should not exceed it.
    localparam int REQ_TAG_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        HOLD
    } state_t;

    typedef struct packed {
        logic [63:0]          op1;
        logic [63:0]          op2;
        logic [2:0]           rm;
        logic                 optype;
        logic                 p;
        logic [REQ_TAG_W-1:0] tag;
    } req_t;

endpackage

// File: rtl/fpdiv_seq_fifo.sv
// DEPTH-entry synchronous request queue with full/empty flags and a show-ahead head.
module fpdiv_seq_fifo
    import fpdiv_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push_i,
    input  logic pop_i,
    input  req_t wdata_i,
    output req_t rdata_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);

    req_t          mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
            if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

    // Extra pointer bit tells a full queue from an empty one when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/fpdiv_seq.sv
// Issue sequencer in front of fpdiv: queues requests, runs one divide at a time, returns
// results with their tag, and resets a hung divider on timeout. Define FPDIV_SEQ_STATS_EN for counters.
module fpdiv_seq
    import fpdiv_seq_pkg::*;
#(
    parameter int TAG_W     = 4,
    parameter int DEPTH     = 4,
    parameter int START_CYC = 2,
    parameter int TIMEOUT   = 31
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [63:0]         req_op1,
    input  logic [63:0]         req_op2,
    input  logic [2:0]          req_rm,
    input  logic                req_optype,
    input  logic                req_p,
    input  logic [TAG_W-1:0]    req_tag,
    output logic                div_start,
    output logic [63:0]         div_op1,
    output logic [63:0]         div_op2,
    output logic [2:0]          div_rm,
    output logic                div_optype,
    output logic                div_p,
    output logic                div_rst,
    input  logic                div_done,
    input  logic [RESULT_W-1:0] div_result,
    input  logic [FLAGS_W-1:0]  div_flags,
    input  logic                div_denorm,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [RESULT_W-1:0] rsp_result,
    output logic [FLAGS_W-1:0]  rsp_flags,
    output logic                rsp_denorm,
    output logic [TAG_W-1:0]    rsp_tag,
    output logic                rsp_timeout
`ifdef FPDIV_SEQ_STATS_EN
    ,
    output logic [31:0]         stat_ops,
    output logic [15:0]         stat_timeouts
`endif
);

    localparam int               CNT_W      = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYC);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(TIMEOUT);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    req_t                  op_q, op_d, req_in, head;
    logic                  full, empty, push, pop;
    logic                  done_q, done_rise;
    logic                  div_start_q, div_start_d;
    logic                  div_rst_q, div_rst_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic                  rsp_denorm_q, rsp_denorm_d;
    logic [RESULT_W-1:0]   rsp_result_q, rsp_result_d;
    logic [FLAGS_W-1:0]    rsp_flags_q, rsp_flags_d;

    // Both ports transfer on a cycle where valid and ready are high at the clock edge; once
    // raised, rsp_valid and its payload hold unchanged until that transfer happens.
    assign req_ready = reset & ~full;
    assign push      = req_valid & req_ready;
    assign done_rise = div_done & ~done_q;

    always_comb begin
        req_in        = '0;
        req_in.op1    = req_op1;
        req_in.op2    = req_op2;
        req_in.rm     = req_rm;
        req_in.optype = req_optype;
        req_in.p      = req_p;
        req_in.tag    = REQ_TAG_W'(req_tag);
    end

    fpdiv_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (req_in),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_d          = op_q;
        pop           = 1'b0;
        div_start_d   = div_start_q;
        div_rst_d     = 1'b0;
        rsp_valid_d   = rsp_valid_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_denorm_d  = rsp_denorm_q;
        rsp_result_d  = rsp_result_q;
        rsp_flags_d   = rsp_flags_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop         = 1'b1;
                    op_d        = head;
                    div_start_d = 1'b1;
                    cnt_d       = CNT_W'(1);
                    state_d     = START;
                end
            end
            START: begin
                if (cnt_q == START_LAST) begin
                    div_start_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT: begin
                // A completion edge on the last allowed cycle still counts as success.
                if (done_rise) begin
                    rsp_result_d  = div_result;
                    rsp_flags_d   = div_flags;
                    rsp_denorm_d  = div_denorm;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    cnt_d         = '0;
                    state_d       = HOLD;
                end else if (cnt_q == WAIT_LAST) begin
                    rsp_result_d  = '0;
                    rsp_flags_d   = '0;
                    rsp_denorm_d  = 1'b0;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    div_rst_d     = 1'b1;
                    cnt_d         = '0;
                    state_d       = HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            op_q          <= '0;
            done_q        <= 1'b0;
            div_start_q   <= 1'b0;
            div_rst_q     <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_denorm_q  <= 1'b0;
            rsp_result_q  <= '0;
            rsp_flags_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_q          <= op_d;
            done_q        <= div_done;
            div_start_q   <= div_start_d;
            div_rst_q     <= div_rst_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_denorm_q  <= rsp_denorm_d;
            rsp_result_q  <= rsp_result_d;
            rsp_flags_q   <= rsp_flags_d;
        end
    end

    assign div_start   = div_start_q;
    assign div_op1     = op_q.op1;
    assign div_op2     = op_q.op2;
    assign div_rm      = op_q.rm;
    assign div_optype  = op_q.optype;
    assign div_p       = op_q.p;
    assign div_rst     = div_rst_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_flags   = rsp_flags_q;
    assign rsp_denorm  = rsp_denorm_q;
    assign rsp_tag     = TAG_W'(op_q.tag);
    assign rsp_timeout = rsp_timeout_q;

`ifdef FPDIV_SEQ_STATS_EN
    logic [31:0] stat_ops_q;
    logic [15:0] stat_timeouts_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_ops_q      <= '0;
            stat_timeouts_q <= '0;
        end else if (rsp_valid_q && rsp_ready) begin
            if (stat_ops_q != '1) stat_ops_q <= stat_ops_q + 32'd1;
            if (rsp_timeout_q && stat_timeouts_q != '1) stat_timeouts_q <= stat_timeouts_q + 16'd1;
        end
    end

    assign stat_ops      = stat_ops_q;
    assign stat_timeouts = stat_timeouts_q;
`endif

endmodule

// File: tb/tb_fpdiv_seq.sv
// Bench for fpdiv_seq: a stand-in divider answers each operation after a planned latency (or
// never), and every response is scored against an expected queue filled when requests are accepted.
module tb_fpdiv_seq;

    localparam int TAG_W     = 4;
    localparam int DEPTH     = 4;
    localparam int START_CYC = 2;
    localparam int TIMEOUT   = 31;
    localparam int EW        = 1 + TAG_W + 70;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [63:0]      req_op1 = '0;
    logic [63:0]      req_op2 = '0;
    logic [2:0]       req_rm = '0;
    logic             req_optype = 1'b0;
    logic             req_p = 1'b0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             div_start;
    logic [63:0]      div_op1, div_op2;
    logic [2:0]       div_rm;
    logic             div_optype, div_p, div_rst;
    logic             div_done;
    logic [63:0]      div_result;
    logic [4:0]       div_flags;
    logic             div_denorm;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [63:0]      rsp_result;
    logic [4:0]       rsp_flags;
    logic             rsp_denorm;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_timeout;
`ifdef FPDIV_SEQ_STATS_EN
    logic [31:0]      stat_ops;
    logic [15:0]      stat_timeouts;
    int               n_rsp = 0;
    int               n_to_rsp = 0;
`endif

    // Divider pins come either from the latency model or from directed manual drive.
    logic             model_en = 1'b1;
    logic             m_done = 1'b0, t_done = 1'b0;
    logic [63:0]      m_result = '0, t_result = '0;
    logic [4:0]       m_flags = '0, t_flags = '0;
    logic             m_denorm = 1'b0, t_denorm = 1'b0;
    assign div_done   = model_en ? m_done   : t_done;
    assign div_result = model_en ? m_result : t_result;
    assign div_flags  = model_en ? m_flags  : t_flags;
    assign div_denorm = model_en ? m_denorm : t_denorm;

    int               n_checks = 0;
    int               n_fail = 0;
    int               rdy_mode = 1;
    logic [EW-1:0]    exp_q[$];
    int               plan_q[$];

    fpdiv_seq #(.TAG_W(TAG_W), .DEPTH(DEPTH), .START_CYC(START_CYC), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op1(req_op1), .req_op2(req_op2),
        .req_rm(req_rm), .req_optype(req_optype), .req_p(req_p), .req_tag(req_tag),
        .div_start(div_start), .div_op1(div_op1), .div_op2(div_op2), .div_rm(div_rm),
        .div_optype(div_optype), .div_p(div_p), .div_rst(div_rst),
        .div_done(div_done), .div_result(div_result), .div_flags(div_flags), .div_denorm(div_denorm),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .rsp_denorm(rsp_denorm), .rsp_tag(rsp_tag), .rsp_timeout(rsp_timeout)
`ifdef FPDIV_SEQ_STATS_EN
        , .stat_ops(stat_ops), .stat_timeouts(stat_timeouts)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Stand-in divider: fp32 quotient by exponent-field subtraction (exact for power-of-two
    // ratios such as 1.0/2.0), other fields folded in so every forwarded pin affects the answer.
    function automatic logic [69:0] ref_div(input logic [63:0] a, input logic [63:0] b,
                                            input logic [2:0] rm, input logic ot, input logic p);
        logic [31:0] hi, lo;
        hi = a[63:32] - b[63:32] + 32'h3F80_0000;
        lo = a[31:0] ^ b[31:0] ^ {28'd0, ot, rm};
        return {a[0] ^ b[1], p, ot, rm, hi, lo};
    endfunction

    function automatic logic [EW-1:0] pack_exp(input logic [69:0] r, input logic [TAG_W-1:0] tag,
                                               input logic to);
        return {to, tag, r};
    endfunction

    // ---------------- drivers ----------------
    always begin
        @(posedge clk);
        #2;
        case (rdy_mode)
            0:       rsp_ready = 1'b0;
            1:       rsp_ready = 1'b1;
            default: rsp_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // lat = 0 plans a divider that never answers; otherwise done rises lat cycles into WAIT.
    task automatic push_req(input logic [63:0] a, input logic [63:0] b, input logic [2:0] rm,
                            input logic ot, input logic p, input logic [TAG_W-1:0] tag, input int lat);
        int guard = 0;
        req_valid = 1'b1; req_op1 = a; req_op2 = b; req_rm = rm;
        req_optype = ot; req_p = p; req_tag = tag;
        while (!req_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("req_accept_in_time", guard < 300, 1'b1);
        @(negedge clk);
        if (lat == 0) exp_q.push_back(pack_exp('0, tag, 1'b1));
        else          exp_q.push_back(pack_exp(ref_div(a, b, rm, ot, p), tag, 1'b0));
        plan_q.push_back(lat);
    endtask

    task automatic wait_start_fall(output int cyc);
        cyc = 0;
        while (!div_start && cyc < 200) begin @(negedge clk); cyc++; end
        while (div_start && cyc < 200) begin @(negedge clk); cyc++; end
        check("start_seen", cyc < 200, 1'b1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    // ---------------- divider model ----------------
    initial begin : divider_model
        logic prev_start;
        int   lat;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            if (model_en && prev_start && !div_start && plan_q.size() != 0) begin
                lat = plan_q.pop_front();
                if (lat > 0) begin
                    repeat (lat - 1) @(negedge clk);
                    {m_denorm, m_flags, m_result} = ref_div(div_op1, div_op2, div_rm, div_optype, div_p);
                    m_done = 1'b1;
                    @(negedge clk);
                    m_done = 1'b0;
                end
            end
            prev_start = div_start;
        end
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (reset && rsp_valid && rsp_ready) begin
            check("rsp_was_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                check("rsp_result", rsp_result, e[63:0]);
                check("rsp_flags", rsp_flags, e[68:64]);
                check("rsp_denorm", rsp_denorm, e[69]);
                check("rsp_tag", rsp_tag, e[70 +: TAG_W]);
                check("rsp_timeout", rsp_timeout, e[EW-1]);
            end
`ifdef FPDIV_SEQ_STATS_EN
            n_rsp++;
            if (rsp_timeout) n_to_rsp++;
`endif
        end
    end

    // ---------------- test sequence ----------------
    initial begin : main
        int n, bad, seen, w, rst_early;
        logic [63:0] a, b;
        logic [2:0]  rm;

        // Reset state
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_div_rst", div_rst, 1'b1);
        check("rst_div_start", div_start, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_div_op1", div_op1, 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_div_rst", div_rst, 1'b0);
        check("post_rst_req_ready", req_ready, 1'b1);

        // 1.0 / 2.0 in fp32, start width, operand stability, pop latency
        rdy_mode = 1;
        push_req(64'h3F80_0000_0000_0000, 64'h4000_0000_0000_0000, 3'b100, 1'b0, 1'b1, 4'd3, 10);
        req_valid = 1'b0;
        check("start_lat_push_cycle", div_start, 1'b0);
        @(negedge clk);
        check("start_lat_pop_cycle", div_start, 1'b1);
        n = 0;
        while (div_start && n < 10) begin @(negedge clk); n++; end
        check("start_width", n, START_CYC);
        bad = 0; w = 0;
        while (!rsp_valid && w < 100) begin
            if (div_op1 !== 64'h3F80_0000_0000_0000 || div_op2 !== 64'h4000_0000_0000_0000) bad++;
            @(negedge clk);
            w++;
        end
        check("ops_stable", bad, 0);
        check("div_1_2_hi", rsp_result[63:32], 32'h3F00_0000);
        check("div_1_2_tag", rsp_tag, 4'd3);
        check("div_1_2_timeout", rsp_timeout, 1'b0);
        drain(200);

        // Five back-to-back requests fill the queue behind the one in flight
        for (int i = 0; i < 5; i++)
            push_req({$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom_range(0, 4)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'(i + 8), $urandom_range(3, 8));
        req_valid = 1'b0;
        check("full_req_ready", req_ready, 1'b0);
        drain(600);

        // Consumer stalls in HOLD: payload must hold and no new start issues
        rdy_mode = 0;
        repeat (2) @(negedge clk);
        push_req({$urandom, $urandom}, {$urandom, $urandom}, 3'd1, 1'b1, 1'b0, 4'd5, 4);
        push_req({$urandom, $urandom}, {$urandom, $urandom}, 3'd2, 1'b0, 1'b1, 4'd6, 6);
        req_valid = 1'b0;
        w = 0;
        while (!rsp_valid && w < 100) begin @(negedge clk); w++; end
        check("hold_rsp_arrived", rsp_valid, 1'b1);
        bad = 0; seen = 0;
        repeat (20) begin
            if (!rsp_valid || rsp_result !== exp_q[0][63:0] || rsp_tag !== exp_q[0][70 +: TAG_W]) bad++;
            if (div_start) seen++;
            @(negedge clk);
        end
        check("hold_payload_stable", bad, 0);
        check("hold_no_start", seen, 0);
        rdy_mode = 1;
        drain(300);

        // Hung divider: timeout response, one-cycle div_rst, then normal service
        push_req({$urandom, $urandom}, {$urandom, $urandom}, 3'd0, 1'b0, 1'b1, 4'd9, 0);
        req_valid = 1'b0;
        wait_start_fall(n);
        w = 0; rst_early = 0;
        while (!rsp_valid && w < 100) begin
            if (div_rst) rst_early++;
            @(negedge clk);
            w++;
        end
        check("timeout_window", (w >= TIMEOUT) && (w <= TIMEOUT + 2), 1'b1);
        check("timeout_no_early_rst", rst_early, 0);
        check("timeout_flag", rsp_timeout, 1'b1);
        check("timeout_div_rst_on", div_rst, 1'b1);
        @(negedge clk);
        check("timeout_div_rst_off", div_rst, 1'b0);
        push_req(64'h4080_0000_0000_0000, 64'h4000_0000_0000_0000, 3'd0, 1'b0, 1'b1, 4'd10, 6);
        req_valid = 1'b0;
        drain(200);

        // Done already high when WAIT begins is not a completion
        model_en = 1'b0;
        t_done = 1'b1;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; rm = 3'd3;
        push_req(a, b, rm, 1'b1, 1'b0, 4'd12, 5);
        req_valid = 1'b0;
        plan_q.delete();
        wait_start_fall(n);
        seen = 0;
        repeat (6) begin
            if (rsp_valid) seen++;
            @(negedge clk);
        end
        check("stale_done_ignored", seen, 0);
        t_done = 1'b0;
        @(negedge clk);
        {t_denorm, t_flags, t_result} = ref_div(a, b, rm, 1'b1, 1'b0);
        t_done = 1'b1;
        @(negedge clk);
        t_done = 1'b0;
        drain(100);
        model_en = 1'b1;

        // Reset during WAIT drops the operation, the queue and any response
        push_req({$urandom, $urandom}, {$urandom, $urandom}, 3'd0, 1'b0, 1'b0, 4'd1, 0);
        push_req({$urandom, $urandom}, {$urandom, $urandom}, 3'd0, 1'b0, 1'b0, 4'd2, 5);
        req_valid = 1'b0;
        wait_start_fall(n);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("midop_rst_div_rst", div_rst, 1'b1);
        check("midop_rst_rsp_valid", rsp_valid, 1'b0);
        exp_q.delete();
        plan_q.delete();
`ifdef FPDIV_SEQ_STATS_EN
        n_rsp = 0;
        n_to_rsp = 0;
`endif
        reset = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (div_start || rsp_valid) seen++;
        end
        check("midop_rst_quiet", seen, 0);

        // Randomized traffic with random consumer backpressure and occasional hangs
        rdy_mode = 2;
        for (int i = 0; i < 40; i++) begin
            push_req({$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                     ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 20));
            if ($urandom_range(0, 3) == 0) begin
                req_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        req_valid = 1'b0;
        drain(6000);

`ifdef FPDIV_SEQ_STATS_EN
        check("stat_ops", stat_ops, 32'(n_rsp));
        check("stat_timeouts", stat_timeouts, 16'(n_to_rsp));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
